// File: rtl/vector_issue_sequencer.sv
// rtl/vector_issue_sequencer.sv - steps one issued instruction across the vector lanes
// Owns the element index and the retire pulse so they can never disagree.
module vector_issue_sequencer #(
  parameter int N     = 6,
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_type,
  input  logic [N-1:0]     vector_len,
  input  logic             flush,
  input  logic             lane_ready,
  output logic             idle,
  output logic             busy,
  output logic             beat_valid,
  output logic [N-1:0]     elem_index,
  output logic [LANES-1:0] lane_mask,
  output logic             finished
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [N:0]   STRIDE_W = (N+1)'(LANES);
  localparam logic [N-1:0] STRIDE   = N'(LANES);

  logic [1:0]   state;
  logic         op_r;
  logic [N-1:0] len_r;
  logic         last_beat;
  logic         beat_taken;

  // Compare in N+1 bits so the final stride of a maximum-length vector cannot wrap.
  assign last_beat  = !op_r || (({1'b0, elem_index} + STRIDE_W) >= {1'b0, len_r});
  assign beat_taken = (state == S_RUN) && lane_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      op_r       <= 1'b0;
      len_r      <= '0;
      elem_index <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          elem_index <= '0;
          if (!flush && start) begin
            op_r  <= op_type;
            len_r <= vector_len;
            state <= (op_type && (vector_len == '0)) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (flush) begin
            state      <= S_IDLE;
            elem_index <= '0;
          end else if (beat_taken) begin
            if (last_beat) state <= S_DONE;
            else           elem_index <= elem_index + STRIDE;
          end
        end
        default: begin
          state      <= S_IDLE;
          elem_index <= '0;
        end
      endcase
    end
  end

  always_comb begin
    lane_mask = '0;
    if (state == S_RUN) begin
      if (!op_r) begin
        lane_mask = LANES'(1);
      end else begin
        for (int i = 0; i < LANES; i++) begin
          lane_mask[i] = ({1'b0, elem_index} + (N+1)'(i)) < {1'b0, len_r};
        end
      end
    end
  end

  assign idle       = (state == S_IDLE);
  assign busy       = (state == S_RUN) || (state == S_DONE);
  assign beat_valid = (state == S_RUN);
  assign finished   = (state == S_DONE);

endmodule

// File: tb/tb_vector_issue_sequencer.sv
// tb/tb_vector_issue_sequencer.sv - directed self-checking bench for vector_issue_sequencer
module tb_vector_issue_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       op_type;
  logic [5:0] vector_len;
  logic       flush;
  logic       lane_ready;
  logic       idle;
  logic       busy;
  logic       beat_valid;
  logic [5:0] elem_index;
  logic [3:0] lane_mask;
  logic       finished;

  int compared   = 0;
  int mismatched = 0;

  vector_issue_sequencer #(.N(6), .LANES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_type    (op_type),
    .vector_len (vector_len),
    .flush      (flush),
    .lane_ready (lane_ready),
    .idle       (idle),
    .busy       (busy),
    .beat_valid (beat_valid),
    .elem_index (elem_index),
    .lane_mask  (lane_mask),
    .finished   (finished)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [5:0] idx, input logic [3:0] mask);
    chk({tag, ".valid"}, 32'(beat_valid), 1);
    chk({tag, ".index"}, 32'(elem_index), 32'(idx));
    chk({tag, ".mask"},  32'(lane_mask),  32'(mask));
    chk({tag, ".fin"},   32'(finished),   0);
  endtask

  task automatic issue(input logic op, input logic [5:0] len);
    start      = 1'b1;
    op_type    = op;
    vector_len = len;
    step();
    start = 1'b0;
  endtask

  logic [5:0] idx19  [5] = '{6'd0, 6'd4, 6'd8, 6'd12, 6'd16};
  logic [3:0] mask19 [5] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h7};

  initial begin
    rst = 1'b0; start = 1'b0; op_type = 1'b0; vector_len = '0;
    flush = 1'b0; lane_ready = 1'b1;
    step();
    step();
    chk("rst.idle",  32'(idle), 1);
    chk("rst.busy",  32'(busy), 0);
    chk("rst.valid", 32'(beat_valid), 0);
    chk("rst.index", 32'(elem_index), 0);
    chk("rst.mask",  32'(lane_mask), 0);
    chk("rst.fin",   32'(finished), 0);
    rst = 1'b1;
    step();

    // Scalar: one beat, finished at T+2, idle at T+3
    issue(1'b0, 6'd5);
    chk_beat("scalar.b0", 6'd0, 4'h1);
    chk("scalar.busy", 32'(busy), 1);
    chk("scalar.idle", 32'(idle), 0);
    step();
    chk("scalar.fin",  32'(finished), 1);
    chk("scalar.valid_off", 32'(beat_valid), 0);
    chk("scalar.mask_off",  32'(lane_mask), 0);
    step();
    chk("scalar.idle_back", 32'(idle), 1);
    chk("scalar.fin_off",   32'(finished), 0);

    // Vector of 19
    issue(1'b1, 6'd19);
    for (int b = 0; b < 5; b++) begin
      chk_beat($sformatf("v19.b%0d", b), idx19[b], mask19[b]);
      step();
    end
    chk("v19.fin",  32'(finished), 1);
    chk("v19.busy", 32'(busy), 1);
    step();
    chk("v19.fin_once", 32'(finished), 0);
    chk("v19.idle",     32'(idle), 1);

    // Backpressure: length 8, stall 3 cycles at index 4
    issue(1'b1, 6'd8);
    chk_beat("bp.b0", 6'd0, 4'hF);
    step();
    chk_beat("bp.b1", 6'd4, 4'hF);
    lane_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      chk_beat($sformatf("bp.hold%0d", s), 6'd4, 4'hF);
    end
    lane_ready = 1'b1;
    step();
    chk("bp.fin", 32'(finished), 1);
    step();
    chk("bp.idle", 32'(idle), 1);

    // Zero length: straight to DONE
    issue(1'b1, 6'd0);
    chk("zero.valid", 32'(beat_valid), 0);
    chk("zero.fin",   32'(finished), 1);
    step();
    chk("zero.idle",  32'(idle), 1);

    // Maximum length 63: 16 beats, last at 60 with mask 0111
    issue(1'b1, 6'd63);
    for (int b = 0; b < 16; b++) begin
      chk_beat($sformatf("max.b%0d", b), 6'(4 * b), (b == 15) ? 4'h7 : 4'hF);
      step();
    end
    chk("max.fin", 32'(finished), 1);
    step();
    chk("max.idle", 32'(idle), 1);

    // Flush at index 8 of a length-20 vector
    issue(1'b1, 6'd20);
    step();
    step();
    chk_beat("flush.b2", 6'd8, 4'hF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush.idle",  32'(idle), 1);
    chk("flush.fin",   32'(finished), 0);
    chk("flush.valid", 32'(beat_valid), 0);
    step();
    chk("flush.fin_after", 32'(finished), 0);

    // Flush beats start in IDLE
    flush = 1'b1;
    issue(1'b1, 6'd8);
    flush = 1'b0;
    chk("flushidle.idle",  32'(idle), 1);
    chk("flushidle.valid", 32'(beat_valid), 0);

    // Start while busy does not relatch the length
    issue(1'b1, 6'd8);
    chk_beat("busy.b0", 6'd0, 4'hF);
    issue(1'b1, 6'd40);
    chk_beat("busy.b1", 6'd4, 4'hF);
    step();
    chk("busy.fin",   32'(finished), 1);
    chk("busy.valid", 32'(beat_valid), 0);
    step();
    chk("busy.idle",  32'(idle), 1);

    // Reset mid-run, then a scalar on the first released cycle
    issue(1'b1, 6'd20);
    step();
    chk_beat("rrun.b1", 6'd4, 4'hF);
    rst = 1'b0;
    step();
    chk("rrun.idle",  32'(idle), 1);
    chk("rrun.busy",  32'(busy), 0);
    chk("rrun.valid", 32'(beat_valid), 0);
    chk("rrun.index", 32'(elem_index), 0);
    chk("rrun.mask",  32'(lane_mask), 0);
    chk("rrun.fin",   32'(finished), 0);
    rst = 1'b1;
    issue(1'b0, 6'd0);
    chk_beat("rrun.scalar", 6'd0, 4'h1);
    step();
    chk("rrun.scalar_fin", 32'(finished), 1);
    step();
    chk("rrun.scalar_idle", 32'(idle), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
